// File: rtl/pipeline_control_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
//   ctrl_state_e          : controller FSM state encoding (BOOT=0, RUN=1, STALL=2)
//   BUBBLE_CNT_W          : width of the remaining-bubble counter
//   COUNTER_WIDTH_DEFAULT : default width of the performance counters
package pipeline_control_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } ctrl_state_e;

    localparam int unsigned BUBBLE_CNT_W          = 4;
    localparam int unsigned COUNTER_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/saturating_event_counter.sv
// Event counter that holds at all-ones instead of wrapping.
//   clock     : rising-edge clock
//   reset     : asynchronous active-low clear
//   increment : count one event this cycle
//   count     : current count value
module saturating_event_counter
    import pipeline_control_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             increment,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Saturating next value.
    always_comb begin
        count_d = count_q;
        if (increment && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline: holds fetch during a
// boot window, inserts load-use bubbles, and flushes the younger stages on
// a redirect from the memory stage.
//   clock, reset                      : clock, async active-low reset
//   rs1Decode, rs2Decode              : source registers in fetch-to-decode
//   memoryReadEnableDecodeToExecute   : load in decode-to-execute
//   rdDecodeToExecute                 : destination in decode-to-execute
//   pcIncrementOrJump                 : redirect from execute-to-memory
//   pcWriteEnable, fetchToDecodeWriteEnable        : pipeline enables
//   fetchToDecodeFlush, decodeToExecuteFlush,
//   executeToMemoryFlush              : bubble-insert controls
//   stallCycleCount, flushEventCount  : saturating performance counters
//   controllerState                   : current FSM state
module pipeline_hazard_controller
    import pipeline_control_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES      = 2,
    parameter int unsigned LOAD_USE_BUBBLES = 2,
    parameter int unsigned COUNTER_WIDTH    = COUNTER_WIDTH_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [4:0]               rs1Decode,
    input  logic [4:0]               rs2Decode,
    input  logic                     memoryReadEnableDecodeToExecute,
    input  logic [4:0]               rdDecodeToExecute,
    input  logic                     pcIncrementOrJump,
    output logic                     pcWriteEnable,
    output logic                     fetchToDecodeWriteEnable,
    output logic                     fetchToDecodeFlush,
    output logic                     decodeToExecuteFlush,
    output logic                     executeToMemoryFlush,
    output logic [COUNTER_WIDTH-1:0] stallCycleCount,
    output logic [COUNTER_WIDTH-1:0] flushEventCount,
    output logic [1:0]               controllerState
);

    localparam int unsigned BOOT_W = (BOOT_CYCLES > 2) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LAST =
        BOOT_W'((BOOT_CYCLES > 0) ? (BOOT_CYCLES - 1) : 0);
    localparam logic [BUBBLE_CNT_W-1:0] BUBBLE_RELOAD =
        BUBBLE_CNT_W'((LOAD_USE_BUBBLES > 1) ? (LOAD_USE_BUBBLES - 1) : 0);
    localparam ctrl_state_e RESET_STATE = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;

    ctrl_state_e             state_q, state_d;
    logic [BOOT_W-1:0]       boot_cnt_q, boot_cnt_d;
    logic [BUBBLE_CNT_W-1:0] remain_q, remain_d;
    logic                    hazard;
    logic                    stall_inc;
    logic                    flush_inc;

    // Conservative load-use detect: rs2 is compared even when unused.
    assign hazard = memoryReadEnableDecodeToExecute
                  && (rdDecodeToExecute != 5'd0)
                  && ((rdDecodeToExecute == rs1Decode) || (rdDecodeToExecute == rs2Decode));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= RESET_STATE;
            boot_cnt_q <= '0;
            remain_q   <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            remain_q   <= remain_d;
        end
    end

    // Next state and combinational pipeline controls.
    always_comb begin
        state_d                  = state_q;
        boot_cnt_d               = boot_cnt_q;
        remain_d                 = remain_q;
        pcWriteEnable            = 1'b1;
        fetchToDecodeWriteEnable = 1'b1;
        fetchToDecodeFlush       = 1'b0;
        decodeToExecuteFlush     = 1'b0;
        executeToMemoryFlush     = 1'b0;
        stall_inc                = 1'b0;
        flush_inc                = 1'b0;

        case (state_q)
            ST_BOOT: begin
                pcWriteEnable        = 1'b0;
                fetchToDecodeFlush   = 1'b1;
                decodeToExecuteFlush = 1'b1;
                executeToMemoryFlush = 1'b1;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d    = ST_RUN;
                    boot_cnt_d = '0;
                end else begin
                    boot_cnt_d = boot_cnt_q + BOOT_W'(1);
                end
            end

            ST_RUN: begin
                // Redirect beats hazard: the load is younger and gets flushed.
                if (pcIncrementOrJump) begin
                    fetchToDecodeFlush   = 1'b1;
                    decodeToExecuteFlush = 1'b1;
                    executeToMemoryFlush = 1'b1;
                    flush_inc            = 1'b1;
                end else if (hazard) begin
                    pcWriteEnable            = 1'b0;
                    fetchToDecodeWriteEnable = 1'b0;
                    decodeToExecuteFlush     = 1'b1;
                    stall_inc                = 1'b1;
                    if (LOAD_USE_BUBBLES > 1) begin
                        state_d  = ST_STALL;
                        remain_d = BUBBLE_RELOAD;
                    end
                end
            end

            ST_STALL: begin
                if (pcIncrementOrJump) begin
                    fetchToDecodeFlush   = 1'b1;
                    decodeToExecuteFlush = 1'b1;
                    executeToMemoryFlush = 1'b1;
                    flush_inc            = 1'b1;
                    remain_d             = '0;
                    state_d              = ST_RUN;
                end else begin
                    pcWriteEnable            = 1'b0;
                    fetchToDecodeWriteEnable = 1'b0;
                    decodeToExecuteFlush     = 1'b1;
                    stall_inc                = 1'b1;
                    remain_d                 = remain_q - BUBBLE_CNT_W'(1);
                    // <= 1 also recovers from a corrupted zero count.
                    if (remain_q <= BUBBLE_CNT_W'(1)) begin
                        remain_d = '0;
                        state_d  = ST_RUN;
                    end
                end
            end

            default: begin
                state_d  = ST_RUN;
                remain_d = '0;
            end
        endcase
    end

    saturating_event_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_cnt (
        .clock     (clock),
        .reset     (reset),
        .increment (stall_inc),
        .count     (stallCycleCount)
    );

    saturating_event_counter #(.WIDTH(COUNTER_WIDTH)) u_flush_cnt (
        .clock     (clock),
        .reset     (reset),
        .increment (flush_inc),
        .count     (flushEventCount)
    );

    assign controllerState = state_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench for pipeline_hazard_controller. Main instance uses
// BOOT_CYCLES=2, LOAD_USE_BUBBLES=2, COUNTER_WIDTH=4 so saturation is cheap to
// reach; a second instance with BOOT_CYCLES=0, LOAD_USE_BUBBLES=1 shares the
// inputs to cover the no-boot reset state and single-bubble hazard.
module tb_pipeline_hazard_controller;

    logic       clock;
    logic       reset;
    logic [4:0] rs1Decode;
    logic [4:0] rs2Decode;
    logic       memRe;
    logic [4:0] rd;
    logic       jump;

    logic       pc_we, fd_we, fd_fl, de_fl, em_fl;
    logic [3:0] stall_cnt, flush_cnt;
    logic [1:0] st;

    logic       pc_we0, fd_we0, fd_fl0, de_fl0, em_fl0;
    logic [7:0] stall_cnt0, flush_cnt0;
    logic [1:0] st0;

    int nvec;
    int nerr;

    pipeline_hazard_controller #(
        .BOOT_CYCLES(2), .LOAD_USE_BUBBLES(2), .COUNTER_WIDTH(4)
    ) dut (
        .clock                           (clock),
        .reset                           (reset),
        .rs1Decode                       (rs1Decode),
        .rs2Decode                       (rs2Decode),
        .memoryReadEnableDecodeToExecute (memRe),
        .rdDecodeToExecute               (rd),
        .pcIncrementOrJump               (jump),
        .pcWriteEnable                   (pc_we),
        .fetchToDecodeWriteEnable        (fd_we),
        .fetchToDecodeFlush              (fd_fl),
        .decodeToExecuteFlush            (de_fl),
        .executeToMemoryFlush            (em_fl),
        .stallCycleCount                 (stall_cnt),
        .flushEventCount                 (flush_cnt),
        .controllerState                 (st)
    );

    pipeline_hazard_controller #(
        .BOOT_CYCLES(0), .LOAD_USE_BUBBLES(1), .COUNTER_WIDTH(8)
    ) dut0 (
        .clock                           (clock),
        .reset                           (reset),
        .rs1Decode                       (rs1Decode),
        .rs2Decode                       (rs2Decode),
        .memoryReadEnableDecodeToExecute (memRe),
        .rdDecodeToExecute               (rd),
        .pcIncrementOrJump               (jump),
        .pcWriteEnable                   (pc_we0),
        .fetchToDecodeWriteEnable        (fd_we0),
        .fetchToDecodeFlush              (fd_fl0),
        .decodeToExecuteFlush            (de_fl0),
        .executeToMemoryFlush            (em_fl0),
        .stallCycleCount                 (stall_cnt0),
        .flushEventCount                 (flush_cnt0),
        .controllerState                 (st0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, land 2 time units after it.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic set_in(input logic m, input logic [4:0] r, input logic [4:0] s1,
                          input logic [4:0] s2, input logic j);
        memRe     = m;
        rd        = r;
        rs1Decode = s1;
        rs2Decode = s2;
        jump      = j;
        #1;
    endtask

    // Packs {pcWE, fdWE, fdFlush, deFlush, emFlush}.
    function automatic logic [4:0] ctl();
        return {pc_we, fd_we, fd_fl, de_fl, em_fl};
    endfunction

    function automatic logic [4:0] ctl0();
        return {pc_we0, fd_we0, fd_fl0, de_fl0, em_fl0};
    endfunction

    initial begin
        nvec  = 0;
        nerr  = 0;
        reset = 1'b0;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #12;

        // Reset values in BOOT and in no-boot instance.
        check_vec("rst_state",     32'(st),         32'd0);
        check_vec("rst_ctl",       32'(ctl()),      32'b01111);
        check_vec("rst_stallcnt",  32'(stall_cnt),  32'd0);
        check_vec("rst_flushcnt",  32'(flush_cnt),  32'd0);
        check_vec("rst0_state",    32'(st0),        32'd1);
        check_vec("rst0_ctl",      32'(ctl0()),     32'b11000);

        // Release reset between edges; two BOOT cycles then RUN.
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_vec("boot_c0_state", 32'(st),    32'd0);
        check_vec("boot_c0_ctl",   32'(ctl()), 32'b01111);
        step();
        check_vec("boot_c1_state", 32'(st),    32'd0);
        check_vec("boot_c1_ctl",   32'(ctl()), 32'b01111);
        step();
        check_vec("boot_run_state", 32'(st),    32'd1);
        check_vec("boot_run_ctl",   32'(ctl()), 32'b11000);

        // Load-use on rs1: bubble in RUN then STALL, then back to RUN.
        set_in(1'b1, 5'd5, 5'd5, 5'd9, 1'b0);
        check_vec("lu_c0_state", 32'(st),    32'd1);
        check_vec("lu_c0_ctl",   32'(ctl()), 32'b00010);
        check_vec("lu0_ctl",     32'(ctl0()), 32'b00010);
        step();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check_vec("lu_c1_state", 32'(st),    32'd2);
        check_vec("lu_c1_ctl",   32'(ctl()), 32'b00010);
        check_vec("lu0_c1_state", 32'(st0),  32'd1);
        check_vec("lu0_c1_ctl",  32'(ctl0()), 32'b11000);
        step();
        check_vec("lu_end_state", 32'(st),        32'd1);
        check_vec("lu_end_ctl",   32'(ctl()),     32'b11000);
        check_vec("lu_stallcnt",  32'(stall_cnt), 32'd2);
        check_vec("lu0_stallcnt", 32'(stall_cnt0), 32'd1);

        // rd = x0 and non-load matches never stall.
        set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        check_vec("rd0_ctl", 32'(ctl()), 32'b11000);
        step();
        set_in(1'b0, 5'd7, 5'd1, 5'd7, 1'b0);
        check_vec("noload_ctl", 32'(ctl()), 32'b11000);
        step();
        check_vec("nostall_state", 32'(st),        32'd1);
        check_vec("nostall_cnt",   32'(stall_cnt), 32'd2);

        // Redirect coinciding with hazard on rs2: redirect wins.
        set_in(1'b1, 5'd3, 5'd1, 5'd3, 1'b1);
        check_vec("redir_haz_ctl", 32'(ctl()), 32'b11111);
        step();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check_vec("redir_haz_state",    32'(st),        32'd1);
        check_vec("redir_haz_flushcnt", 32'(flush_cnt), 32'd1);
        check_vec("redir_haz_stallcnt", 32'(stall_cnt), 32'd2);

        // Redirect in first STALL cycle.
        set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        step();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        check_vec("stall_redir_state", 32'(st),    32'd2);
        check_vec("stall_redir_ctl",   32'(ctl()), 32'b11111);
        step();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check_vec("stall_redir_next",  32'(st),        32'd1);
        check_vec("stall_redir_fcnt",  32'(flush_cnt), 32'd2);
        check_vec("stall_redir_scnt",  32'(stall_cnt), 32'd3);

        // Reset mid-STALL aborts immediately.
        set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        step();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check_vec("pre_rst_state", 32'(st), 32'd2);
        reset = 1'b0;
        #1;
        check_vec("midrst_state", 32'(st),        32'd0);
        check_vec("midrst_ctl",   32'(ctl()),     32'b01111);
        check_vec("midrst_scnt",  32'(stall_cnt), 32'd0);
        check_vec("midrst_fcnt",  32'(flush_cnt), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        step();
        step();
        check_vec("reboot_state", 32'(st), 32'd1);

        // Continuous hazard: every cycle counts; 4-bit counter holds at 15.
        set_in(1'b1, 5'd12, 5'd12, 5'd12, 1'b0);
        for (int i = 0; i < 14; i++) step();
        check_vec("sat_pre", 32'(stall_cnt), 32'd14);
        for (int i = 0; i < 6; i++) step();
        check_vec("sat_hold", 32'(stall_cnt), 32'd15);
        for (int i = 0; i < 3; i++) step();
        check_vec("sat_hold2", 32'(stall_cnt), 32'd15);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        check_vec("sat_exit_state", 32'(st), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
